// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient type for the noise/NTT datapath.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumed by the streamer and encode paths.
package kyber_pkg;

  localparam int KYBER_Q     = 3329;
  localparam int KYBER_N     = 256;
  localparam int COEFF_W     = 12;
  localparam int CBD_W       = 4;
  localparam int NOISE_POLYS = 7;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/cbd_to_modq.sv
// Maps one 4-bit signed CBD sample to its representative in [0, Q-1] and flags |v| > 2.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the output with its own handshake.
module cbd_to_modq
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int W = COEFF_W
) (
  input  logic [CBD_W-1:0] cbd_i,
  output logic [W-1:0]     modq_o,
  output logic             out_of_range_o
);

  localparam logic [W-1:0] QW = W'(Q);

  logic [W-1:0] sext;

  // Negative samples fold to Q+v using W-bit wraparound arithmetic; the same
  // rule applies across the whole -8..7 range, so no saturation is needed.
  always_comb begin
    sext           = {{(W-CBD_W){cbd_i[CBD_W-1]}}, cbd_i};
    modq_o         = cbd_i[CBD_W-1] ? (QW + sext) : sext;
    // Legal eta=2 samples are 0,1,2 and the two's-complement codes of -1,-2.
    out_of_range_o = !((cbd_i <= CBD_W'(2)) || (cbd_i >= CBD_W'((2 ** CBD_W) - 2)));
  end

endmodule

// File: rtl/cbd_coeff_streamer.sv
// Buffers packed CBD noise polys (two slots) and streams them one mod-Q coefficient per cycle.
// Latency: first coefficient valid the cycle after capture; back-to-back polys stream with no bubble.
// Backpressure: coeff side stalls on !coeff_ready; a poly strobe arriving while both slots are full is dropped and flagged.
module cbd_coeff_streamer #(
  parameter int Q         = kyber_pkg::KYBER_Q,
  parameter int COEFF_W   = kyber_pkg::COEFF_W,
  parameter int NUM_POLYS = kyber_pkg::NOISE_POLYS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1023:0]       poly_in,
  input  logic                poly_valid,
  output logic                poly_ready,
  output logic [COEFF_W-1:0]  coeff_out,
  output logic                coeff_valid,
  input  logic                coeff_ready,
  output logic [7:0]          coeff_idx,
  output logic [2:0]          poly_idx,
  output logic                last_coeff,
  output logic                last_poly,
  output logic                ovf_err,
  output logic                range_err
);

  import kyber_pkg::*;

  localparam logic [7:0] LAST_CIDX = 8'(KYBER_N - 1);
  localparam logic [2:0] LAST_PIDX = 3'(NUM_POLYS - 1);

  // Slot payload carries no reset: every output derived from it is qualified
  // by occupancy, which is reset.
  logic [KYBER_N*CBD_W-1:0] slot_q [2];

  logic        wr_sel_q;
  logic        rd_sel_q;
  logic [1:0]  count_q, count_d;
  logic [7:0]  cidx_q;
  logic [2:0]  pidx_q;
  logic        ovf_q;
  logic        range_q;

  logic               cap;
  logic               drop;
  logic               hs;
  logic               free;
  logic               valid_int;
  logic [CBD_W-1:0]   nib;
  logic [COEFF_W-1:0] mapped;
  logic               bad;

  // Occupancy decode, handshake qualification and nibble selection.
  always_comb begin
    valid_int = rst_n && (count_q != 2'd0);
    cap       = poly_valid && (count_q != 2'd2);
    drop      = poly_valid && (count_q == 2'd2);
    hs        = valid_int && coeff_ready;
    free      = hs && (cidx_q == LAST_CIDX);
    nib       = slot_q[rd_sel_q][{cidx_q, 2'b00} +: CBD_W];
  end

  cbd_to_modq #(
    .Q (Q),
    .W (COEFF_W)
  ) u_map (
    .cbd_i          (nib),
    .modq_o         (mapped),
    .out_of_range_o (bad)
  );

  // Net occupancy change: simultaneous capture and free cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({cap, free})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Write the captured poly into the slot the write pointer selects.
  always_ff @(posedge clk) begin
    if (cap) begin
      slot_q[wr_sel_q] <= poly_in;
    end
  end

  // Pointer, index, occupancy and sticky-error state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      count_q  <= 2'd0;
      cidx_q   <= 8'd0;
      pidx_q   <= 3'd0;
      ovf_q    <= 1'b0;
      range_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (cap) begin
        wr_sel_q <= ~wr_sel_q;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (hs) begin
        cidx_q <= cidx_q + 8'd1;
        if (bad) begin
          range_q <= 1'b1;
        end
      end
      if (free) begin
        rd_sel_q <= ~rd_sel_q;
        pidx_q   <= (pidx_q == LAST_PIDX) ? 3'd0 : (pidx_q + 3'd1);
      end
    end
  end

  // Outputs are gated by rst_n so they read as idle for the whole reset
  // window, including the cycle before the first reset edge lands.
  always_comb begin
    poly_ready  = rst_n && (count_q != 2'd2);
    coeff_valid = valid_int;
    coeff_out   = valid_int ? mapped : '0;
    coeff_idx   = rst_n ? cidx_q : 8'd0;
    poly_idx    = rst_n ? pidx_q : 3'd0;
    last_coeff  = valid_int && (cidx_q == LAST_CIDX);
    last_poly   = valid_int && (cidx_q == LAST_CIDX) && (pidx_q == LAST_PIDX);
    ovf_err     = rst_n && ovf_q;
    range_err   = rst_n && range_q;
  end

endmodule

// File: tb/tb_cbd_coeff_streamer.sv
// Scoreboard bench for the CBD coefficient streamer with a poly-level reference model.
// Expected coefficients are queued when a strobe is judged accepted; a negedge monitor pops and compares.
// Exercises bursts, overflow drops, poly index wrap, random backpressure and mid-stream reset.
module tb_cbd_coeff_streamer;

  localparam int Q = 3329;
  localparam int NP = 7;

  logic          clk;
  logic          rst_n;
  logic [1023:0] poly_in;
  logic          poly_valid;
  logic          poly_ready;
  logic [11:0]   coeff_out;
  logic          coeff_valid;
  logic          coeff_ready;
  logic [7:0]    coeff_idx;
  logic [2:0]    poly_idx;
  logic          last_coeff;
  logic          last_poly;
  logic          ovf_err;
  logic          range_err;

  cbd_coeff_streamer #(.Q(Q), .COEFF_W(12), .NUM_POLYS(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .poly_in     (poly_in),
    .poly_valid  (poly_valid),
    .poly_ready  (poly_ready),
    .coeff_out   (coeff_out),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeff_idx   (coeff_idx),
    .poly_idx    (poly_idx),
    .last_coeff  (last_coeff),
    .last_poly   (last_poly),
    .ovf_err     (ovf_err),
    .range_err   (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int out;
    int idx;
    int pidx;
    bit bad;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   occ      = 0;   // polys accepted but not yet fully consumed
  int   occ_pre;
  int   cap_cnt  = 0;   // polys accepted since reset, gives the poly index
  bit   ovf_exp  = 0;
  bit   range_exp = 0;
  int   hs_cnt   = 0;
  int   lp_cnt   = 0;
  bit   prev_stall = 0;
  int   prev_out;
  int   prev_idx;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted poly contributes 256 coefficients, v mapped to v or Q+v.
  task automatic model_accept(input logic [1023:0] p);
    for (int i = 0; i < 256; i++) begin
      exp_t x;
      int   n;
      int   v;
      n = int'(p[4*i +: 4]);
      v = (n >= 8) ? n - 16 : n;
      x.out  = (v < 0) ? Q + v : v;
      x.idx  = i;
      x.pidx = cap_cnt % NP;
      x.bad  = (v < -2) || (v > 2);
      exp_q.push_back(x);
    end
    cap_cnt++;
    occ++;
  endtask

  // Monitor: compares everything the DUT shows in this cycle, then applies
  // the events the coming edge will commit (handshake, capture or drop).
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs_zero",
            {coeff_valid, coeff_out, coeff_idx, poly_idx, last_coeff, last_poly,
             ovf_err, range_err, poly_ready}, 0);
      exp_q.delete();
      occ = 0; cap_cnt = 0; ovf_exp = 0; range_exp = 0; prev_stall = 0;
    end else begin
      occ_pre = occ;
      check("coeff_valid", coeff_valid, occ != 0);
      check("poly_ready", poly_ready, occ < 2);
      check("ovf_err", ovf_err, ovf_exp);
      check("range_err", range_err, range_exp);
      if (prev_stall) begin
        check("stall_stable_out", coeff_out, prev_out);
        check("stall_stable_idx", coeff_idx, prev_idx);
      end
      if (coeff_valid) begin
        if (exp_q.size() == 0) begin
          check("expected_available", 0, 1);
        end else begin
          e = exp_q[0];
          check("coeff_out", coeff_out, e.out);
          check("coeff_idx", coeff_idx, e.idx);
          check("poly_idx", poly_idx, e.pidx);
          check("last_coeff", last_coeff, e.idx == 255);
          check("last_poly", last_poly, (e.idx == 255) && (e.pidx == NP - 1));
          if (coeff_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            if (last_poly) lp_cnt++;
            if (e.bad) range_exp = 1;
            if (e.idx == 255) occ--;
          end
        end
      end
      prev_stall = coeff_valid && !coeff_ready;
      prev_out   = int'(coeff_out);
      prev_idx   = int'(coeff_idx);
      if (poly_valid) begin
        if (occ_pre < 2) model_accept(poly_in);
        else             ovf_exp = 1;
      end
    end
  end

  function automatic logic [1023:0] rand_poly();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1023:0] rand_small_poly();
    logic [1023:0] r;
    logic [3:0]    tab [5];
    tab = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
    for (int i = 0; i < 256; i++) r[4*i +: 4] = tab[$urandom_range(0, 4)];
    return r;
  endfunction

  // All driver tasks start and end at posedge+1.
  task automatic send_poly(input logic [1023:0] p);
    poly_in    = p;
    poly_valid = 1'b1;
    @(posedge clk); #1;
    poly_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!coeff_valid) done = 1;
    end
    check({name, "_drain_timeout"}, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (poly_ready) done = 1;
      else begin @(posedge clk); #1; end
    end
    check("poly_ready_timeout", done, 1);
  endtask

  int hs0;
  int lp0;
  logic [1023:0] p;

  initial begin
    rst_n = 1'b0; poly_valid = 1'b0; coeff_ready = 1'b0; poly_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Directed poly: E,2,0,F then zeros -> 3327,2,0,3328,0...
    coeff_ready = 1'b1;
    p = '0;
    p[15:0] = 16'hF02E;
    hs0 = hs_cnt;
    send_poly(p);
    wait_idle("single");
    check("single_handshakes", hs_cnt - hs0, 256);

    // Two back-to-back captures, third strobe lands on a full buffer.
    hs0 = hs_cnt;
    send_poly(rand_small_poly());
    send_poly(rand_small_poly());
    send_poly(rand_small_poly());
    check("burst_ovf_set", ovf_err, 1);
    wait_idle("burst");
    check("burst_handshakes", hs_cnt - hs0, 512);

    // Eight polys from a fresh reset: poly index wraps after the seventh.
    do_reset();
    lp0 = lp_cnt;
    for (int k = 0; k < 8; k++) begin
      wait_ready();
      send_poly(rand_small_poly());
    end
    wait_idle("seq8");
    check("seq8_last_poly_pulses", lp_cnt - lp0, 1);

    // Random backpressure and random strobes with arbitrary nibbles.
    for (int c = 0; c < 4000; c++) begin
      coeff_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        poly_in    = rand_poly();
        poly_valid = 1'b1;
      end else begin
        poly_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    poly_valid  = 1'b0;
    coeff_ready = 1'b1;
    wait_idle("random");

    // Out-of-range sample then reset mid-poly.
    do_reset();
    p = '0;
    p[23:20] = 4'h7;
    send_poly(p);
    begin
      bit hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
        @(negedge clk);
        if (coeff_valid && coeff_idx == 8'd100) hit = 1;
      end
      check("reach_idx100_timeout", hit, 1);
    end
    @(posedge clk); #1;
    check("range_err_sticky", range_err, 1);
    do_reset();
    check("post_reset_range_err", range_err, 0);
    check("post_reset_coeff_valid", coeff_valid, 0);
    send_poly(rand_small_poly());
    wait_idle("after_reset");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
